// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad/button front-end conditioning stage.
// Optional build macro: KEYPAD_REPEAT_EN (auto-repeat strobes while a key is held).
package keypad_pkg;

  localparam int KEY_W = 10;

  // Idle (reset) levels of the debounced outputs.
  localparam logic [KEY_W-1:0] KEY_IDLE = '0;
  localparam logic             BTN_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_e;

  // True when exactly one key line is asserted.
  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - {{(KEY_W-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debouncer for one active-low push button.
// The output only flips after the synced input has disagreed with it for
// DEBOUNCE_CYCLES+1 consecutive samples, giving the same latency as the keypad path.
module button_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button line into the clock domain.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= BTN_IDLE;
      sync2 <= BTN_IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level <= BTN_IDLE;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == DEB_MAX) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/keypad_debouncer.sv
// Keypad and button conditioning ahead of the microwave top level.
// Synchronises the raw 10-key pad, accepts only single-key presses that stay
// stable, and emits a one-hot level plus a one-cycle strobe per press.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat strobes every
// REPEAT_CYCLES cycles while a key is held.
// Handshake: key_strobe is a pure one-cycle valid with no ready; keypad is
// stable whenever key_strobe is high and the consumer must take it that cycle.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [KEY_W-1:0] keypad_raw,
  input  logic             startn_raw,
  input  logic             stopn_raw,
  input  logic             clearn_raw,
  output logic [KEY_W-1:0] keypad,
  output logic             key_strobe,
  output logic             startn,
  output logic             stopn,
  output logic             clearn,
  output key_state_e       dbg_state
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [KEY_W-1:0] ks_s1;
  logic [KEY_W-1:0] ks;
  key_state_e       state;
  key_state_e       state_next;
  logic [KEY_W-1:0] code;
  logic [KEY_W-1:0] code_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [KEY_W-1:0] keypad_next;
  logic             strobe_next;
  logic             rep_fire;

  // Two-flop synchroniser for the key lines.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ks_s1 <= KEY_IDLE;
      ks    <= KEY_IDLE;
    end else begin
      ks_s1 <= keypad_raw;
      ks    <= ks_s1;
    end
  end

  // State register together with the registered key outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      code       <= KEY_IDLE;
      cnt        <= '0;
      keypad     <= KEY_IDLE;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_next;
      code       <= code_next;
      cnt        <= cnt_next;
      keypad     <= keypad_next;
      key_strobe <= strobe_next;
    end
  end

  // Next-state logic: a key must stay the only key for the whole debounce
  // window, and a release must stay clean for the same window.
  always_comb begin
    state_next = state;
    code_next  = code;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (is_one_hot(ks)) begin
          code_next  = ks;
          cnt_next   = ONE;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks != code) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt == DEB_MAX) begin
          cnt_next   = '0;
          state_next = HELD;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      HELD: begin
        if (ks == '0) begin
          cnt_next   = ONE;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (ks != '0) begin
          cnt_next   = '0;
          state_next = HELD;
        end else if (cnt == DEB_MAX) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep;
  logic [CNT_W-1:0] rep_next;

  // Repeat counter runs only while staying in HELD; any exit clears it, so a
  // return from RELEASE restarts the repeat period from zero.
  always_comb begin
    rep_next = '0;
    rep_fire = 1'b0;
    if (state == HELD && state_next == HELD) begin
      if (rep == REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_next = rep + ONE;
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rep <= '0;
    end else begin
      rep <= rep_next;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Output logic: the level follows the accepted code while held or releasing.
  always_comb begin
    keypad_next = KEY_IDLE;
    if (state_next == HELD || state_next == RELEASE) begin
      keypad_next = code_next;
    end
    strobe_next = ((state == DEBOUNCE) && (state_next == HELD)) || rep_fire;
    dbg_state   = state;
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clock  (clock),
    .resetn (resetn),
    .raw    (startn_raw),
    .level  (startn)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clock  (clock),
    .resetn (resetn),
    .raw    (stopn_raw),
    .level  (stopn)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock  (clock),
    .resetn (resetn),
    .raw    (clearn_raw),
    .level  (clearn)
  );

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with default parameters (4 / 8).
// Expected events carry {cycle, value}; a negedge monitor pops and compares.
module tb_keypad_debouncer;
  import keypad_pkg::*;

  localparam int EW = 26;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             resetn;
  logic [KEY_W-1:0] keypad_raw;
  logic             startn_raw;
  logic             stopn_raw;
  logic             clearn_raw;
  logic [KEY_W-1:0] keypad;
  logic             key_strobe;
  logic             startn;
  logic             stopn;
  logic             clearn;
  key_state_e       dbg_state;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  keypad_debouncer dut (
    .clock      (clock),
    .resetn     (resetn),
    .keypad_raw (keypad_raw),
    .startn_raw (startn_raw),
    .stopn_raw  (stopn_raw),
    .clearn_raw (clearn_raw),
    .keypad     (keypad),
    .key_strobe (key_strobe),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_strobe_q[$];
  logic [EW-1:0] exp_key_q[$];
  logic [EW-1:0] exp_start_q[$];
  logic [EW-1:0] exp_stop_q[$];
  logic [EW-1:0] exp_clear_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [EW-1:0] ev(input int c, input logic [KEY_W-1:0] v);
    return {c[15:0], v};
  endfunction

  task automatic compare(input string name, input logic [EW-1:0] act,
                         input logic have, input logic [EW-1:0] exp);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s: unexpected event at cycle %0d value 0x%0h, expected none",
               name, act[EW-1:KEY_W], act[KEY_W-1:0]);
    end else if (act !== exp) begin
      failures++;
      $display("FAIL %s: got cycle %0d value 0x%0h, expected cycle %0d value 0x%0h",
               name, act[EW-1:KEY_W], act[KEY_W-1:0], exp[EW-1:KEY_W], exp[KEY_W-1:0]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [KEY_W-1:0] prev_key   = '0;
  logic             prev_start = 1'b1;
  logic             prev_stop  = 1'b1;
  logic             prev_clear = 1'b1;
  logic [EW-1:0]    e;
  logic             have;

  always @(negedge clock) begin
    if (key_strobe === 1'b1) begin
      have = exp_strobe_q.size() > 0;
      e = '0;
      if (have) e = exp_strobe_q.pop_front();
      compare("key_strobe", ev(cyc, keypad), have, e);
    end
    if (keypad !== prev_key) begin
      have = exp_key_q.size() > 0;
      e = '0;
      if (have) e = exp_key_q.pop_front();
      compare("keypad_level", ev(cyc, keypad), have, e);
      prev_key = keypad;
    end
    if (startn !== prev_start) begin
      have = exp_start_q.size() > 0;
      e = '0;
      if (have) e = exp_start_q.pop_front();
      compare("startn_level", ev(cyc, {9'b0, startn}), have, e);
      prev_start = startn;
    end
    if (stopn !== prev_stop) begin
      have = exp_stop_q.size() > 0;
      e = '0;
      if (have) e = exp_stop_q.pop_front();
      compare("stopn_level", ev(cyc, {9'b0, stopn}), have, e);
      prev_stop = stopn;
    end
    if (clearn !== prev_clear) begin
      have = exp_clear_q.size() > 0;
      e = '0;
      if (have) e = exp_clear_q.pop_front();
      compare("clearn_level", ev(cyc, {9'b0, clearn}), have, e);
      prev_clear = clearn;
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a negedge: drive a clean press held for `hold` cycles, then release.
  task automatic press_key(input logic [KEY_W-1:0] code, input int hold);
    int k;
    k = cyc;
    keypad_raw = code;
    exp_strobe_q.push_back(ev(k + 7, code));
    exp_key_q.push_back(ev(k + 7, code));
`ifdef KEYPAD_REPEAT_EN
    for (int t = k + 15; t < k + hold + 3; t += 8) exp_strobe_q.push_back(ev(t, code));
`endif
    repeat (hold) @(negedge clock);
    keypad_raw = '0;
    exp_key_q.push_back(ev(cyc + 7, '0));
    repeat (12) @(negedge clock);
  endtask

  // Called on a negedge: hold one button low for `len` cycles (0 start, 1 stop, 2 clear).
  task automatic press_btn(input int which, input int len);
    int s;
    s = cyc;
    if (len >= 10) begin
      case (which)
        0: begin exp_start_q.push_back(ev(s + 7, '0)); exp_start_q.push_back(ev(s + len + 7, 10'd1)); end
        1: begin exp_stop_q.push_back(ev(s + 7, '0));  exp_stop_q.push_back(ev(s + len + 7, 10'd1));  end
        default: begin exp_clear_q.push_back(ev(s + 7, '0)); exp_clear_q.push_back(ev(s + len + 7, 10'd1)); end
      endcase
    end
    case (which)
      0: startn_raw = 1'b0;
      1: stopn_raw  = 1'b0;
      default: clearn_raw = 1'b0;
    endcase
    repeat (len) @(negedge clock);
    case (which)
      0: startn_raw = 1'b1;
      1: stopn_raw  = 1'b1;
      default: clearn_raw = 1'b1;
    endcase
    repeat (12) @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_keypad"}, 32'(keypad), 32'h0);
    check_val({tag, "_strobe"}, 32'(key_strobe), 32'h0);
    check_val({tag, "_startn"}, 32'(startn), 32'h1);
    check_val({tag, "_stopn"},  32'(stopn),  32'h1);
    check_val({tag, "_clearn"}, 32'(clearn), 32'h1);
    check_val({tag, "_state"},  32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    resetn     = 1'b0;
    keypad_raw = '0;
    startn_raw = 1'b1;
    stopn_raw  = 1'b1;
    clearn_raw = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    // Clean press of bit 3.
    press_key(10'h008, 20);

    // Bit 5 bouncing every 2 cycles, then stable.
    for (int i = 0; i < 3; i++) begin
      keypad_raw = 10'h020;
      repeat (2) @(negedge clock);
      keypad_raw = '0;
      repeat (2) @(negedge clock);
    end
    press_key(10'h020, 10);

    // Two keys together are rejected; the survivor alone is accepted.
    keypad_raw = 10'h084;
    repeat (20) @(negedge clock);
    press_key(10'h080, 12);

    // Glitch on start, real presses on stop and clear.
    press_btn(0, 3);
    press_btn(1, 10);
    press_btn(2, 10);

    // Start pressed while a key is debouncing: independent paths.
    fork
      press_key(10'h001, 12);
      press_btn(0, 12);
    join

    // Reset in the middle of a held key.
    k = cyc;
    keypad_raw = 10'h002;
    exp_strobe_q.push_back(ev(k + 7, 10'h002));
    exp_key_q.push_back(ev(k + 7, 10'h002));
    repeat (12) @(negedge clock);
    @(posedge clock);
    #3;
    resetn = 1'b0;
    exp_key_q.push_back(ev(cyc, '0));
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    k = cyc;
    exp_strobe_q.push_back(ev(k + 7, 10'h002));
    exp_key_q.push_back(ev(k + 7, 10'h002));
    repeat (10) @(negedge clock);
    keypad_raw = '0;
    exp_key_q.push_back(ev(cyc + 7, '0));
    repeat (12) @(negedge clock);

    // Long hold of bit 9 (repeat strobes only when the feature is built in).
    press_key(10'h200, 40);

    repeat (20) @(negedge clock);
    check_val("strobe_q_empty", 32'(exp_strobe_q.size()), 32'h0);
    check_val("key_q_empty",    32'(exp_key_q.size()),    32'h0);
    check_val("start_q_empty",  32'(exp_start_q.size()),  32'h0);
    check_val("stop_q_empty",   32'(exp_stop_q.size()),   32'h0);
    check_val("clear_q_empty",  32'(exp_clear_q.size()),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
